// File: rtl/header_restore_if.sv
// rtl/header_restore_if.sv - header/block input and restored-header output bundle for header_restore.
interface header_restore_if;
  logic [159:0] hdr_in;
  logic         hdr_valid;
  logic         direct;
  logic [127:0] blk_in;
  logic         blk_valid;
  logic         blk_last;
  logic [159:0] hdr_out;
  logic [15:0]  length;
  logic [3:0]   pad_size;
  logic         done;
  logic         err;
  logic         busy;

  modport master (
    output hdr_in, hdr_valid, direct, blk_in, blk_valid, blk_last,
    input  hdr_out, length, pad_size, done, err, busy
  );

  modport slave (
    input  hdr_in, hdr_valid, direct, blk_in, blk_valid, blk_last,
    output hdr_out, length, pad_size, done, err, busy
  );
endinterface

// File: rtl/header_restore.sv
// rtl/header_restore.sv - strips AES padding from a decrypted IPv4 packet and restores length/checksum.
// Optional macro HDR_CHECK_EN: verify the received header checksum (direct packets then take the SUM/FOLD path).
module header_restore #(
  parameter int CNT_W = 12
) (
  input  logic clk,
  input  logic reset,
  header_restore_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COLLECT, SUM, FOLD, DONE} state_t;

  state_t state, state_nxt;

  logic [159:0]     hdr_r;
  logic             direct_r;
  logic [CNT_W-1:0] count;
  logic [7:0]       p_r;
  logic [3:0]       idx;
  logic [19:0]      acc;

  logic [159:0] hdr_out_r;
  logic [15:0]  length_r;
  logic [3:0]   pad_r;
  logic         done_r;
  logic         err_r;

  logic [15:0] tl;
  logic        marker;
  logic [16:0] len_ext;
  logic [16:0] cnt_bytes;
  logic        pad_err;
  logic [15:0] new_tl;
  logic [15:0] raw_word;
  logic [15:0] mod_word;
  logic [15:0] cks;
  logic        chk_err;
  logic        err_final;
  logic        rewrite;
  logic        unused_blk_bits;

  // Two end-around-carry folds are enough for a 20-bit sum of ten 16-bit words.
  function automatic logic [15:0] fold20(input logic [19:0] s);
    logic [16:0] f1;
    f1 = {1'b0, s[15:0]} + {13'b0, s[19:16]};
    return f1[15:0] + {15'b0, f1[16]};
  endfunction

  assign tl        = hdr_r[143:128];
  assign marker    = hdr_r[111];
  assign len_ext   = {1'b0, tl} - 17'd20;
  assign cnt_bytes = 17'({count, 4'b0000});
  assign pad_err   = marker && !direct_r &&
                     ((p_r == 8'd0) || (p_r > 8'd15) || (len_ext != cnt_bytes));
  assign new_tl    = (marker && !pad_err) ? (tl - {8'h00, p_r}) : tl;
  assign cks       = ~fold20(acc);

  always_comb begin
    raw_word = 16'h0000;
    case (idx)
      4'd0:    raw_word = hdr_r[159:144];
      4'd1:    raw_word = hdr_r[143:128];
      4'd2:    raw_word = hdr_r[127:112];
      4'd3:    raw_word = hdr_r[111:96];
      4'd4:    raw_word = hdr_r[95:80];
      4'd5:    raw_word = hdr_r[79:64];
      4'd6:    raw_word = hdr_r[63:48];
      4'd7:    raw_word = hdr_r[47:32];
      4'd8:    raw_word = hdr_r[31:16];
      4'd9:    raw_word = hdr_r[15:0];
      default: raw_word = 16'h0000;
    endcase
  end

  always_comb begin
    mod_word = raw_word;
    case (idx)
      4'd1:    mod_word = new_tl;
      4'd3:    mod_word = raw_word & 16'h7FFF;
      4'd5:    mod_word = 16'h0000;
      default: mod_word = raw_word;
    endcase
  end

`ifdef HDR_CHECK_EN
  logic [19:0] acc_rx;

  always_ff @(posedge clk) begin
    if (reset || state != SUM) begin
      acc_rx <= 20'd0;
    end else begin
      acc_rx <= acc_rx + {4'b0, raw_word};
    end
  end

  assign chk_err = (fold20(acc_rx) != 16'hFFFF);
`else
  assign chk_err = 1'b0;
`endif

  assign err_final = pad_err || chk_err;
  assign rewrite   = !direct_r && marker && !err_final;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.hdr_valid && !bus.direct) begin
          state_nxt = COLLECT;
        end
`ifdef HDR_CHECK_EN
        if (bus.hdr_valid && bus.direct) begin
          state_nxt = SUM;
        end
`endif
      end
      COLLECT: if (bus.blk_valid && bus.blk_last) state_nxt = SUM;
      SUM:     if (idx == 4'd9) state_nxt = FOLD;
      FOLD:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_r     <= '0;
      direct_r  <= 1'b0;
      count     <= '0;
      p_r       <= 8'd0;
      idx       <= 4'd0;
      acc       <= 20'd0;
      hdr_out_r <= '0;
      length_r  <= 16'd0;
      pad_r     <= 4'd0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hdr_valid) begin
            hdr_r    <= bus.hdr_in;
            direct_r <= bus.direct;
            count    <= '0;
`ifndef HDR_CHECK_EN
            if (bus.direct) begin
              hdr_out_r <= bus.hdr_in;
              length_r  <= bus.hdr_in[143:128] - 16'd20;
              pad_r     <= 4'd0;
              err_r     <= 1'b0;
              done_r    <= 1'b1;
            end
`endif
          end
        end
        COLLECT: begin
          if (bus.blk_valid) begin
            if (count != '1) count <= count + 1'b1;
            if (bus.blk_last) p_r <= bus.blk_in[7:0];
          end
        end
        FOLD: begin
          hdr_out_r <= rewrite ? {hdr_r[159:144], new_tl, hdr_r[127:112], 1'b0,
                                  hdr_r[110:80], cks, hdr_r[63:0]}
                               : hdr_r;
          length_r  <= (rewrite ? new_tl : tl) - 16'd20;
          pad_r     <= rewrite ? p_r[3:0] : 4'd0;
          err_r     <= err_final;
          done_r    <= 1'b1;
        end
        default: ;
      endcase

      if (state == SUM) begin
        acc <= acc + {4'b0, mod_word};
        idx <= idx + 4'd1;
      end else begin
        acc <= 20'd0;
        idx <= 4'd0;
      end
    end
  end

  // Only the pad-count byte of the final block matters here.
  assign unused_blk_bits = ^bus.blk_in[127:8];

  assign bus.hdr_out  = hdr_out_r;
  assign bus.length   = length_r;
  assign bus.pad_size = pad_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_header_restore.sv
// tb/tb_header_restore.sv - table-driven scoreboard bench for header_restore.
module tb_header_restore;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  header_restore_if bus();

  header_restore dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

`ifdef HDR_CHECK_EN
  localparam int DIRECT_LAT = 12;
`else
  localparam int DIRECT_LAT = 1;
`endif

  typedef struct {
    logic [15:0] tl;
    logic        marker;
    logic        direct;
    int          nblk;
    logic [7:0]  lastb;
    logic        exp_err;
    logic [15:0] exp_len;
    logic [3:0]  exp_pad;
  } vec_t;

  typedef struct {
    logic [159:0] hdr;
    logic [15:0]  len;
    logic [3:0]   pad;
    logic         err;
    int           cyc;
    int           id;
  } exp_t;

  vec_t vt [9];
  exp_t sb [$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] csum(input logic [159:0] h);
    int unsigned s;
    logic [15:0] w;
    s = 0;
    for (int i = 0; i < 10; i++) begin
      w = h[159 - 16*i -: 16];
      s += w;
    end
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return ~(16'(s));
  endfunction

  function automatic logic [159:0] mk_hdr(input logic [15:0] tl, input logic marker);
    logic [159:0] h;
    h = {16'h4500, tl, 16'h1c46, marker, 1'b1, 14'h0000, 16'h4011, 16'h0000,
         32'hc0a80001, 32'hc0a800c7};
    h[79:64] = csum(h);
    return h;
  endfunction

  function automatic logic [159:0] restore(input logic [159:0] h, input logic [7:0] p);
    logic [159:0] r;
    r = h;
    r[143:128] = h[143:128] - {8'h00, p};
    r[111] = 1'b0;
    r[79:64] = 16'h0000;
    r[79:64] = csum(r);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("v%0d_hdr_out", mon_e.id), bus.hdr_out, mon_e.hdr);
        chk($sformatf("v%0d_length", mon_e.id), 160'(bus.length), 160'(mon_e.len));
        chk($sformatf("v%0d_pad_size", mon_e.id), 160'(bus.pad_size), 160'(mon_e.pad));
        chk($sformatf("v%0d_err", mon_e.id), 160'(bus.err), 160'(mon_e.err));
        chk($sformatf("v%0d_done_cycle", mon_e.id), 160'(cyc), 160'(mon_e.cyc));
      end
    end
  end

  task automatic run_vec(input int i);
    vec_t v;
    exp_t e;
    logic [159:0] h;
    logic [127:0] b;
    v = vt[i];
    h = mk_hdr(v.tl, v.marker);
    e.hdr = (v.exp_err || !v.marker || v.direct) ? h : restore(h, v.lastb);
    e.len = v.exp_len;
    e.pad = v.exp_pad;
    e.err = v.exp_err;
    e.id  = i;
    e.cyc = 0;
    @(posedge clk);
    #1;
    bus.hdr_in = h;
    bus.hdr_valid = 1'b1;
    bus.direct = v.direct;
    if (v.direct) begin
      e.cyc = cyc + DIRECT_LAT;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.hdr_valid = 1'b0;
    bus.direct = 1'b0;
    if (!v.direct) begin
      for (int k = 0; k < v.nblk; k++) begin
        b = {$urandom, $urandom, $urandom, $urandom};
        if (k == v.nblk - 1) b[7:0] = v.lastb;
        bus.blk_in = b;
        bus.blk_valid = 1'b1;
        bus.blk_last = (k == v.nblk - 1);
        if (k == v.nblk - 1) begin
          e.cyc = cyc + 12;
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.blk_valid = 1'b0;
        bus.blk_last = 1'b0;
        if (k == 0) begin
          chk($sformatf("v%0d_busy", i), 160'(bus.busy), 160'(1));
          @(posedge clk);
          #1;
        end
      end
    end
    for (int w = 0; w < 40 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL v%0d_timeout: no done within 40 cycles, required done at cycle %0d", i, sb[0].cyc);
      sb.delete();
    end
    @(posedge clk);
  endtask

  initial begin
    vt[0] = '{16'h0034, 1'b0, 1'b0, 2, 8'h00, 1'b0, 16'd32, 4'd0};
    vt[1] = '{16'h0034, 1'b1, 1'b0, 2, 8'h05, 1'b0, 16'd27, 4'd5};
    vt[2] = '{16'h0034, 1'b1, 1'b0, 2, 8'h00, 1'b1, 16'd32, 4'd0};
    vt[3] = '{16'h0034, 1'b1, 1'b0, 2, 8'h10, 1'b1, 16'd32, 4'd0};
    vt[4] = '{16'h0044, 1'b1, 1'b0, 2, 8'h05, 1'b1, 16'd48, 4'd0};
    vt[5] = '{16'h0034, 1'b1, 1'b1, 0, 8'h00, 1'b0, 16'd32, 4'd0};
    vt[6] = '{16'h0044, 1'b1, 1'b0, 3, 8'h0F, 1'b0, 16'd33, 4'd15};
    vt[7] = '{16'h0024, 1'b1, 1'b0, 1, 8'h01, 1'b0, 16'd15, 4'd1};
    vt[8] = '{16'h0024, 1'b0, 1'b0, 1, 8'h07, 1'b0, 16'd16, 4'd0};

    bus.hdr_in = '0;
    bus.hdr_valid = 1'b0;
    bus.direct = 1'b0;
    bus.blk_in = '0;
    bus.blk_valid = 1'b0;
    bus.blk_last = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_hdr_out", bus.hdr_out, 160'd0);
    chk("reset_length", 160'(bus.length), 160'd0);
    chk("reset_pad_size", 160'(bus.pad_size), 160'd0);
    chk("reset_done", 160'(bus.done), 160'd0);
    chk("reset_err", 160'(bus.err), 160'd0);
    chk("reset_busy", 160'(bus.busy), 160'd0);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Stray blocks while idle must not start anything.
    @(posedge clk);
    #1;
    bus.blk_in = {$urandom, $urandom, $urandom, 32'h00000003};
    bus.blk_valid = 1'b1;
    bus.blk_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.blk_valid = 1'b0;
    bus.blk_last = 1'b0;
    @(negedge clk);
    chk("stray_blk_busy", 160'(bus.busy), 160'd0);
    chk("stray_blk_done", 160'(bus.done), 160'd0);
    run_vec(1);

    // Reset during SUM cycle 5 aborts with no done.
    @(posedge clk);
    #1;
    bus.hdr_in = mk_hdr(16'h0034, 1'b1);
    bus.hdr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.hdr_valid = 1'b0;
    bus.blk_in = {$urandom, $urandom, $urandom, 32'h00000000};
    bus.blk_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.blk_in = {$urandom, $urandom, $urandom, 32'h00000005};
    bus.blk_last = 1'b1;
    @(posedge clk);
    #1;
    bus.blk_valid = 1'b0;
    bus.blk_last = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sum_busy", 160'(bus.busy), 160'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_hdr_out", bus.hdr_out, 160'd0);
    chk("abort_length", 160'(bus.length), 160'd0);
    chk("abort_pad_size", 160'(bus.pad_size), 160'd0);
    chk("abort_err", 160'(bus.err), 160'd0);
    chk("abort_busy", 160'(bus.busy), 160'd0);
    repeat (20) @(posedge clk);
    run_vec(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
